nearest_block_reducer: RTL and testbench
========================================

// Module: nearest_block_reducer
// PURPOSE
// Sits directly downstream of the per-block ray/block intersection stage. That stage emits one
// beat per (pixel, block), with blocks in index order 0..NUM_BLOCKS-1 for each pixel.
// This block reduces those beats to one result per pixel: the visible intersecting block with the
// smallest positive hit distance t. The result goes to the shading/colour stage.
// PARAMETERS
// NUM_BLOCKS    13           beats per pixel; block indices 0..NUM_BLOCKS-1 (index 12 = saber)
// NO_HIT_INDEX  4'd15        block_index_out value when no block is hit
// PORTS
// clk_in              in   1   system clock
// rst_in              in   1   synchronous, active-high reset
// x_in                in   11  pixel x of current beat
// y_in                in   10  pixel y of current beat
// ray_x_in/_y_in/_z_in in  32  ray direction, IEEE-754 single
// block_index_in      in   4   block index of current beat
// intersect_in        in   1   ray hits this block AND block is visible
// t_in                in   32  hit distance, IEEE-754 single
// valid_in            in   1   beat qualifier; gaps allowed between beats
// x_out, y_out        out  11/10  pixel of the reduced result
// ray_out_x/_y/_z     out  32  ray direction of the reduced pixel
// block_index_out     out  4   nearest hit block, or NO_HIT_INDEX
// hit_out             out  1   at least one block hit
// best_t_out          out  32  t of the nearest hit; 32'h7F80_0000 (+inf) if no hit
// valid_out           out  1   one-cycle pulse per completed pixel
// seq_error_out       out  1   one-cycle pulse on a beat-order violation
// BEHAVIOUR
// - Reset: all outputs 0 except block_index_out=NO_HIT_INDEX and best_t_out=+inf. FSM goes to IDLE
//   and expected index goes to 0. A partially accumulated pixel is discarded with no output.
// - Qualifying beat: valid_in=1 and intersect_in=1 and t_in[31]=0 and t_in!=0 and t_in[30:23]!=8'hFF.
//   Negative, zero, inf and NaN t never qualify.
// - t comparison: qualifying t values are positive floats, so they are compared as 31-bit unsigned
//   integers on t[30:0]. No float IP is used.
// - Tie rule: a strict less-than replaces the current best, so the lower block index wins on equal t.
// - FSM IDLE: a valid beat with index 0 does the following:
//   - latch x/y/ray;
//   - init best to this beat if qualifying, else to the no-hit state;
//   - expected := 1, go to ACCUM.
//   A valid beat with index !=0 in IDLE pulses seq_error_out and is dropped.
// - FSM ACCUM: a valid beat with index==expected updates best and increments expected.
//   - Index==NUM_BLOCKS-1 completes the pixel: the registered result appears with valid_out=1 on the
//     next cycle, and the FSM returns to IDLE.
//   - NUM_BLOCKS==1 completes on the index-0 beat directly from IDLE.
// - Sequence violation in ACCUM: a valid beat with index!=expected pulses seq_error_out and
//   discards the accumulation.
//   - If that beat has index 0, it starts a new pixel in the same cycle (stay in ACCUM, expected=1).
//   - Otherwise the FSM goes to IDLE.
// - Throughput: an index-0 beat in the cycle right after the last beat is accepted (IDLE processes it
//   the same cycle the result is registered). Back-to-back pixels sustain 1 beat/cycle.
// - Latency: the last beat enters at cycle n; valid_out=1 at cycle n+1.
// - Held outputs: outputs other than valid_out and seq_error_out hold their last value between pulses.
// - Ignored beats: valid_in=0 beats are ignored entirely, and the FSM and expected index hold.
// - Pixel coordinates: x/y/ray are taken from the index-0 beat only. Mismatches on later beats are
//   not checked.
// TESTING
// 1. Single pixel (5,7) with 13 beats and only block 4 hitting, t=2.0 (0x40000000) ->
//    one valid_out; hit_out=1, block_index_out=4, best_t_out=0x40000000, x/y=5/7.
// 2. Blocks 2 and 9 both hit with equal t=1.5, and block 11 hits with t=3.0 ->
//    block_index_out=2, best_t_out=0x3FC00000.
// 3. No hits; one beat has intersect=1 with t=-1.0, another with t=NaN ->
//    hit_out=0, block_index_out=15, best_t_out=0x7F800000.
// 4. Two pixels back-to-back, 26 consecutive beats with no gaps, plus a third pixel with random
//    valid gaps -> exactly 3 valid_out pulses, each 1 cycle after its index-12 beat, with correct
//    per-pixel results.
// 5. Index sequence 0,1,2,5 -> seq_error_out pulses on the 5 beat and no valid_out. Next sequence
//    0..12 with a hit at block 0 -> normal result.
// 6. rst_in asserted after beat 6 of a pixel -> no valid_out. After release, a full pixel reduces
//    correctly and no stale best carries over.

Source files
------------

// File: rtl/nearest_block_reducer.sv
// Nearest-block reducer: collapses the per-(pixel, block) intersection beats
// into one result per pixel. The result is the qualifying hit with the
// smallest positive t, and the lower block index wins on equal t.
//
// Ports:
//   clk_in, rst_in             clock, synchronous active-high reset
//   x_in, y_in                 pixel coordinates of the current beat
//   ray_x_in/_y_in/_z_in       ray direction (IEEE-754 single)
//   block_index_in             block index of the current beat
//   intersect_in, t_in         hit flag and hit distance of the current beat
//   valid_in                   beat qualifier (gaps allowed)
//   x_out, y_out, ray_out_*    pixel and ray of the reduced result
//   block_index_out            nearest hit block or NO_HIT_INDEX
//   hit_out, best_t_out        any-hit flag, nearest t (+inf when no hit)
//   valid_out                  one-cycle pulse per completed pixel
//   seq_error_out              one-cycle pulse on a beat-order violation
module nearest_block_reducer #(
  parameter int unsigned NUM_BLOCKS   = 13,
  parameter logic [3:0]  NO_HIT_INDEX = 4'd15
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [10:0] x_in,
  input  logic [9:0]  y_in,
  input  logic [31:0] ray_x_in,
  input  logic [31:0] ray_y_in,
  input  logic [31:0] ray_z_in,
  input  logic [3:0]  block_index_in,
  input  logic        intersect_in,
  input  logic [31:0] t_in,
  input  logic        valid_in,
  output logic [10:0] x_out,
  output logic [9:0]  y_out,
  output logic [31:0] ray_out_x,
  output logic [31:0] ray_out_y,
  output logic [31:0] ray_out_z,
  output logic [3:0]  block_index_out,
  output logic        hit_out,
  output logic [31:0] best_t_out,
  output logic        valid_out,
  output logic        seq_error_out
);

  localparam int unsigned IDX_W = 4;
  localparam int unsigned X_W   = 11;
  localparam int unsigned Y_W   = 10;
  localparam int unsigned F_W   = 32;
  localparam int unsigned MAG_W = 31;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BLOCKS - 1);
  // +inf magnitude; any qualifying t is strictly smaller than this.
  localparam logic [MAG_W-1:0] INF_MAG  = 31'h7F80_0000;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t             state_q, state_n;
  logic [IDX_W-1:0]   expected_q, expected_n;

  // Running best of the pixel being accumulated
  logic               acc_hit_q, acc_hit_n;
  logic [IDX_W-1:0]   acc_idx_q, acc_idx_n;
  logic [MAG_W-1:0]   acc_t_q, acc_t_n;

  // Pixel context latched from the index-0 beat
  logic [X_W-1:0]     px_x_q, px_x_n;
  logic [Y_W-1:0]     px_y_q, px_y_n;
  logic [F_W-1:0]     px_rx_q, px_rx_n;
  logic [F_W-1:0]     px_ry_q, px_ry_n;
  logic [F_W-1:0]     px_rz_q, px_rz_n;

  // Next values of the registered outputs
  logic [X_W-1:0]     x_n;
  logic [Y_W-1:0]     y_n;
  logic [F_W-1:0]     rx_n, ry_n, rz_n;
  logic [IDX_W-1:0]   idx_out_n;
  logic               hit_n;
  logic [F_W-1:0]     t_out_n;
  logic               valid_n;
  logic               seq_err_n;

  // Per-beat decode
  logic               qual;
  logic               start;
  logic               advance;
  logic               upd;
  logic               base_hit;
  logic [IDX_W-1:0]   base_idx;
  logic [MAG_W-1:0]   base_t;
  logic               m_hit;
  logic [IDX_W-1:0]   m_idx;
  logic [MAG_W-1:0]   m_t;

  // Only positive, non-zero, finite t can be a hit
  assign qual = valid_in && intersect_in && !t_in[31] &&
                (t_in[MAG_W-1:0] != '0) && (t_in[30:23] != 8'hFF);

  // State and datapath registers
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q         <= IDLE;
      expected_q      <= '0;
      acc_hit_q       <= 1'b0;
      acc_idx_q       <= NO_HIT_INDEX;
      acc_t_q         <= INF_MAG;
      px_x_q          <= '0;
      px_y_q          <= '0;
      px_rx_q         <= '0;
      px_ry_q         <= '0;
      px_rz_q         <= '0;
      x_out           <= '0;
      y_out           <= '0;
      ray_out_x       <= '0;
      ray_out_y       <= '0;
      ray_out_z       <= '0;
      block_index_out <= NO_HIT_INDEX;
      hit_out         <= 1'b0;
      best_t_out      <= {1'b0, INF_MAG};
      valid_out       <= 1'b0;
      seq_error_out   <= 1'b0;
    end else begin
      state_q         <= state_n;
      expected_q      <= expected_n;
      acc_hit_q       <= acc_hit_n;
      acc_idx_q       <= acc_idx_n;
      acc_t_q         <= acc_t_n;
      px_x_q          <= px_x_n;
      px_y_q          <= px_y_n;
      px_rx_q         <= px_rx_n;
      px_ry_q         <= px_ry_n;
      px_rz_q         <= px_rz_n;
      x_out           <= x_n;
      y_out           <= y_n;
      ray_out_x       <= rx_n;
      ray_out_y       <= ry_n;
      ray_out_z       <= rz_n;
      block_index_out <= idx_out_n;
      hit_out         <= hit_n;
      best_t_out      <= t_out_n;
      valid_out       <= valid_n;
      seq_error_out   <= seq_err_n;
    end
  end

  // Next-state, accumulation and output logic
  always_comb begin
    state_n    = state_q;
    expected_n = expected_q;
    acc_hit_n  = acc_hit_q;
    acc_idx_n  = acc_idx_q;
    acc_t_n    = acc_t_q;
    px_x_n     = px_x_q;
    px_y_n     = px_y_q;
    px_rx_n    = px_rx_q;
    px_ry_n    = px_ry_q;
    px_rz_n    = px_rz_q;
    x_n        = x_out;
    y_n        = y_out;
    rx_n       = ray_out_x;
    ry_n       = ray_out_y;
    rz_n       = ray_out_z;
    idx_out_n  = block_index_out;
    hit_n      = hit_out;
    t_out_n    = best_t_out;
    valid_n    = 1'b0;
    seq_err_n  = 1'b0;
    start      = 1'b0;
    advance    = 1'b0;

    if (valid_in) begin
      case (state_q)
        IDLE: begin
          if (block_index_in == '0) start = 1'b1;
          else                      seq_err_n = 1'b1;
        end
        ACCUM: begin
          if (block_index_in == expected_q) begin
            advance = 1'b1;
          end else begin
            seq_err_n = 1'b1;
            // An out-of-order index 0 restarts a pixel in the same cycle
            if (block_index_in == '0) begin
              start = 1'b1;
            end else begin
              state_n    = IDLE;
              expected_n = '0;
            end
          end
        end
        default: begin
          state_n    = IDLE;
          expected_n = '0;
        end
      endcase
    end

    // A new pixel merges against the no-hit state, otherwise against the running best
    base_hit = start ? 1'b0 : acc_hit_q;
    base_idx = start ? NO_HIT_INDEX : acc_idx_q;
    base_t   = start ? INF_MAG : acc_t_q;
    // Strict less-than keeps the earlier (lower) index on ties
    upd      = qual && (t_in[MAG_W-1:0] < base_t);
    m_hit    = upd ? 1'b1 : base_hit;
    m_idx    = upd ? block_index_in : base_idx;
    m_t      = upd ? t_in[MAG_W-1:0] : base_t;

    if (start) begin
      px_x_n  = x_in;
      px_y_n  = y_in;
      px_rx_n = ray_x_in;
      px_ry_n = ray_y_in;
      px_rz_n = ray_z_in;
    end

    if (start || advance) begin
      if (block_index_in == LAST_IDX) begin
        x_n        = px_x_n;
        y_n        = px_y_n;
        rx_n       = px_rx_n;
        ry_n       = px_ry_n;
        rz_n       = px_rz_n;
        idx_out_n  = m_idx;
        hit_n      = m_hit;
        t_out_n    = {1'b0, m_t};
        valid_n    = 1'b1;
        state_n    = IDLE;
        expected_n = '0;
      end else begin
        acc_hit_n  = m_hit;
        acc_idx_n  = m_idx;
        acc_t_n    = m_t;
        expected_n = block_index_in + IDX_W'(1);
        state_n    = ACCUM;
      end
    end
  end

endmodule

// File: tb/tb_nearest_block_reducer.sv
// Scoreboard bench for nearest_block_reducer: the driver pushes hand-computed
// results (with the cycle they must appear) and a negedge monitor checks them.
module tb_nearest_block_reducer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [10:0] x_in;
  logic [9:0]  y_in;
  logic [31:0] ray_x_in, ray_y_in, ray_z_in;
  logic [3:0]  block_index_in;
  logic        intersect_in;
  logic [31:0] t_in;
  logic        valid_in;
  logic [10:0] x_out;
  logic [9:0]  y_out;
  logic [31:0] ray_out_x, ray_out_y, ray_out_z;
  logic [3:0]  block_index_out;
  logic        hit_out;
  logic [31:0] best_t_out;
  logic        valid_out;
  logic        seq_error_out;

  nearest_block_reducer dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .x_in(x_in), .y_in(y_in),
    .ray_x_in(ray_x_in), .ray_y_in(ray_y_in), .ray_z_in(ray_z_in),
    .block_index_in(block_index_in), .intersect_in(intersect_in),
    .t_in(t_in), .valid_in(valid_in),
    .x_out(x_out), .y_out(y_out),
    .ray_out_x(ray_out_x), .ray_out_y(ray_out_y), .ray_out_z(ray_out_z),
    .block_index_out(block_index_out), .hit_out(hit_out),
    .best_t_out(best_t_out), .valid_out(valid_out),
    .seq_error_out(seq_error_out)
  );

  always #5 clk_in = ~clk_in;

  typedef struct {
    logic [10:0] x;
    logic [9:0]  y;
    logic [31:0] rx, ry, rz;
    logic [3:0]  idx;
    logic        hit;
    logic [31:0] t;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   err_q[$];
  exp_t pend;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;

  logic [10:0] cur_x;
  logic [9:0]  cur_y;
  logic        hit_en[13];
  logic [31:0] hit_t[13];

  always @(posedge clk_in) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every output pulse must match the head of its queue
  always @(negedge clk_in) begin
    if (valid_out === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_valid_out", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("valid_cycle", 32'(cyc), 32'(e.cyc));
        chk("x_out", 32'(x_out), 32'(e.x));
        chk("y_out", 32'(y_out), 32'(e.y));
        chk("ray_out_x", ray_out_x, e.rx);
        chk("ray_out_y", ray_out_y, e.ry);
        chk("ray_out_z", ray_out_z, e.rz);
        chk("block_index_out", 32'(block_index_out), 32'(e.idx));
        chk("hit_out", 32'(hit_out), 32'(e.hit));
        chk("best_t_out", best_t_out, e.t);
      end
    end
    if (seq_error_out === 1'b1) begin
      if (err_q.size() == 0) chk("unexpected_seq_error", 32'd1, 32'd0);
      else                   chk("seq_error_cycle", 32'(cyc), 32'(err_q.pop_front()));
    end
  end

  function automatic logic [31:0] rx_of(input logic [10:0] x);
    return 32'h3F00_0000 | 32'(x);
  endfunction

  // Drive one beat for one cycle; push the pending result or a seq error if flagged
  task automatic beat(input logic [3:0] idx, input logic inter, input logic [31:0] t,
                      input bit last, input bit bad);
    valid_in       = 1'b1;
    x_in           = cur_x;
    y_in           = cur_y;
    ray_x_in       = rx_of(cur_x);
    ray_y_in       = 32'h4000_0000 | 32'(cur_y);
    ray_z_in       = 32'hBF80_0000 ^ 32'(cur_x);
    block_index_in = idx;
    intersect_in   = inter;
    t_in           = t;
    if (last) begin
      pend.cyc = cyc + 1;
      exp_q.push_back(pend);
    end
    if (bad) err_q.push_back(cyc + 1);
    @(posedge clk_in);
    #1;
    valid_in       = 1'b0;
    x_in           = 11'h7FF;
    intersect_in   = 1'b1;
    t_in           = 32'h0000_0001;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
    end
  endtask

  task automatic clear_hits();
    for (int i = 0; i < 13; i++) begin
      hit_en[i] = 1'b0;
      hit_t[i]  = 32'h3E80_0000;  // small t on non-intersecting beats must be ignored
    end
  endtask

  task automatic set_exp(input logic [3:0] idx, input logic hit, input logic [31:0] t);
    pend.x   = cur_x;
    pend.y   = cur_y;
    pend.rx  = rx_of(cur_x);
    pend.ry  = 32'h4000_0000 | 32'(cur_y);
    pend.rz  = 32'hBF80_0000 ^ 32'(cur_x);
    pend.idx = idx;
    pend.hit = hit;
    pend.t   = t;
  endtask

  task automatic send_pixel(input bit gaps);
    for (int i = 0; i < 13; i++) begin
      if (gaps) idle($urandom_range(0, 2));
      beat(4'(i), hit_en[i], hit_t[i], i == 12, 1'b0);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_x"}, 32'(x_out), 32'd0);
    chk({tag, "_idx"}, 32'(block_index_out), 32'd15);
    chk({tag, "_hit"}, 32'(hit_out), 32'd0);
    chk({tag, "_t"}, best_t_out, 32'h7F80_0000);
    chk({tag, "_valid"}, 32'(valid_out), 32'd0);
    chk({tag, "_seqerr"}, 32'(seq_error_out), 32'd0);
  endtask

  initial begin
    rst_in = 1'b1; valid_in = 1'b0; x_in = '0; y_in = '0;
    ray_x_in = '0; ray_y_in = '0; ray_z_in = '0;
    block_index_in = '0; intersect_in = 1'b0; t_in = '0;
    idle(3);
    @(negedge clk_in);
    chk_reset_outputs("reset");
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    idle(2);

    // 1: only block 4 hits, t = 2.0
    cur_x = 11'd5; cur_y = 10'd7; clear_hits();
    hit_en[4] = 1'b1; hit_t[4] = 32'h4000_0000;
    set_exp(4'd4, 1'b1, 32'h4000_0000);
    send_pixel(1'b0);
    idle(3);

    // 2: tie at 1.5 between blocks 2 and 9, block 11 farther
    cur_x = 11'd100; cur_y = 10'd200; clear_hits();
    hit_en[2] = 1'b1;  hit_t[2]  = 32'h3FC0_0000;
    hit_en[9] = 1'b1;  hit_t[9]  = 32'h3FC0_0000;
    hit_en[11] = 1'b1; hit_t[11] = 32'h4040_0000;
    set_exp(4'd2, 1'b1, 32'h3FC0_0000);
    send_pixel(1'b0);
    idle(2);

    // 3: only non-qualifying t values (negative, NaN, zero, +inf)
    cur_x = 11'd1; cur_y = 10'd2; clear_hits();
    hit_en[1] = 1'b1; hit_t[1] = 32'hBF80_0000;
    hit_en[6] = 1'b1; hit_t[6] = 32'h7FC0_0000;
    hit_en[8] = 1'b1; hit_t[8] = 32'h0000_0000;
    hit_en[10] = 1'b1; hit_t[10] = 32'h7F80_0000;
    set_exp(4'd15, 1'b0, 32'h7F80_0000);
    send_pixel(1'b0);
    idle(2);

    // 4: two back-to-back pixels, then one with random gaps
    cur_x = 11'd1919; cur_y = 10'd1079; clear_hits();
    hit_en[5] = 1'b1;  hit_t[5]  = 32'h3FA0_0000;
    hit_en[12] = 1'b1; hit_t[12] = 32'h3F80_0000;
    set_exp(4'd12, 1'b1, 32'h3F80_0000);
    send_pixel(1'b0);
    cur_x = 11'd640; cur_y = 10'd480; clear_hits();
    hit_en[0] = 1'b1; hit_t[0] = 32'h4100_0000;
    hit_en[1] = 1'b1; hit_t[1] = 32'h0000_0001;  // denormal is the smallest
    hit_en[2] = 1'b1; hit_t[2] = 32'h7F80_0000;
    set_exp(4'd1, 1'b1, 32'h0000_0001);
    send_pixel(1'b0);
    cur_x = 11'd33; cur_y = 10'd44; clear_hits();
    hit_en[6] = 1'b1; hit_t[6] = 32'h3F80_0001;
    hit_en[7] = 1'b1; hit_t[7] = 32'h3F80_0000;
    set_exp(4'd7, 1'b1, 32'h3F80_0000);
    send_pixel(1'b1);
    idle(2);

    // 5: sequence 0,1,2,5 aborts, then a clean pixel with a hit at block 0
    cur_x = 11'd9; cur_y = 10'd9;
    beat(4'd0, 1'b1, 32'h3E00_0000, 1'b0, 1'b0);
    beat(4'd1, 1'b0, 32'h0, 1'b0, 1'b0);
    beat(4'd2, 1'b0, 32'h0, 1'b0, 1'b0);
    beat(4'd5, 1'b0, 32'h0, 1'b0, 1'b1);
    idle(1);
    cur_x = 11'd10; cur_y = 10'd11; clear_hits();
    hit_en[0] = 1'b1; hit_t[0] = 32'h3F00_0000;
    hit_en[3] = 1'b1; hit_t[3] = 32'h3F00_0000;
    set_exp(4'd0, 1'b1, 32'h3F00_0000);
    send_pixel(1'b0);
    idle(1);

    // Non-zero index in IDLE is dropped with an error
    beat(4'd3, 1'b1, 32'h3F80_0000, 1'b0, 1'b1);
    // Out-of-order index 0 in ACCUM restarts from that beat
    cur_x = 11'd20; cur_y = 10'd20;
    beat(4'd0, 1'b1, 32'h3C00_0000, 1'b0, 1'b0);
    beat(4'd1, 1'b0, 32'h0, 1'b0, 1'b0);
    cur_x = 11'd21; cur_y = 10'd22;
    beat(4'd0, 1'b0, 32'h0, 1'b0, 1'b1);
    clear_hits();
    hit_en[8] = 1'b1; hit_t[8] = 32'h3F00_0000;
    set_exp(4'd8, 1'b1, 32'h3F00_0000);
    for (int i = 1; i < 13; i++) beat(4'(i), hit_en[i], hit_t[i], i == 12, 1'b0);
    idle(2);

    // 6: reset mid-pixel, partial hit at block 3 must not survive
    cur_x = 11'd77; cur_y = 10'd66;
    for (int i = 0; i <= 6; i++) beat(4'(i), i == 3, 32'h3E80_0000, 1'b0, 1'b0);
    rst_in = 1'b1;
    idle(2);
    rst_in = 1'b0;
    @(negedge clk_in);
    chk_reset_outputs("midreset");
    @(posedge clk_in); #1;
    cur_x = 11'd78; cur_y = 10'd67; clear_hits();
    hit_en[7] = 1'b1; hit_t[7] = 32'h4080_0000;
    set_exp(4'd7, 1'b1, 32'h4080_0000);
    send_pixel(1'b0);

    idle(5);
    chk("results_outstanding", 32'(exp_q.size()), 32'd0);
    chk("seq_errors_outstanding", 32'(err_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety net: the stimulus is finite, but never let a stuck run hang
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, cycle %0d", cyc);
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "timeout");
  end

endmodule
